// File: rtl/fft32_pkg.sv
// Shared constants, state encoding and index helpers for the 32-point FFT sequencer.
package fft32_pkg;
   localparam int DW    = 13;
   localparam int TW    = 8;
   localparam int N     = 32;
   localparam int LOG2N = 5;

   typedef enum logic [1:0] {
      LOAD,
      COMPUTE,
      UNLOAD
   } state_t;

   function automatic logic [4:0] bitrev5(input logic [4:0] v);
      return {v[0], v[1], v[2], v[3], v[4]};
   endfunction
endpackage

// File: rtl/fft32_twiddle_rom.sv
// Twiddle table W_k = exp(-j*2*pi*k/32) for k = 0..15, scaled so that 64 = 1.0.
module fft32_twiddle_rom
   import fft32_pkg::*;
(
   input  logic        [3:0]    k,
   output logic signed [TW-1:0] w_re,
   output logic signed [TW-1:0] w_im
);
   always_comb begin
      w_re = 8'sd64;
      w_im = 8'sd0;
      case (k)
         4'd0:  begin w_re =  8'sd64; w_im =  8'sd0;  end
         4'd1:  begin w_re =  8'sd63; w_im = -8'sd12; end
         4'd2:  begin w_re =  8'sd59; w_im = -8'sd24; end
         4'd3:  begin w_re =  8'sd53; w_im = -8'sd36; end
         4'd4:  begin w_re =  8'sd45; w_im = -8'sd45; end
         4'd5:  begin w_re =  8'sd36; w_im = -8'sd53; end
         4'd6:  begin w_re =  8'sd24; w_im = -8'sd59; end
         4'd7:  begin w_re =  8'sd12; w_im = -8'sd63; end
         4'd8:  begin w_re =  8'sd0;  w_im = -8'sd64; end
         4'd9:  begin w_re = -8'sd12; w_im = -8'sd63; end
         4'd10: begin w_re = -8'sd24; w_im = -8'sd59; end
         4'd11: begin w_re = -8'sd36; w_im = -8'sd53; end
         4'd12: begin w_re = -8'sd45; w_im = -8'sd45; end
         4'd13: begin w_re = -8'sd53; w_im = -8'sd36; end
         4'd14: begin w_re = -8'sd59; w_im = -8'sd24; end
         4'd15: begin w_re = -8'sd63; w_im = -8'sd12; end
         default: begin w_re = 8'sd64; w_im = 8'sd0; end
      endcase
   end
endmodule

// File: rtl/fft32_bfly_sequencer.sv
// In-place radix-2 DIT FFT sequencer: owns sample memory, feeds an external butterfly MAC.
//   state   | meaning
//   LOAD    | accept 32 samples, store bit-reversed
//   COMPUTE | 5 stages x 16 butterflies, one per cycle, written back in place
//   UNLOAD  | stream X[0..31] in natural order under valid/ready
module fft32_bfly_sequencer
   import fft32_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_re,
   output logic signed [DW-1:0] out_im,
   output logic                 busy,
   output logic                 frame_done,
   output logic signed [DW-1:0] mac_a_re,
   output logic signed [DW-1:0] mac_a_im,
   output logic signed [DW-1:0] mac_b_re,
   output logic signed [DW-1:0] mac_b_im,
   output logic signed [TW-1:0] mac_w_re,
   output logic signed [TW-1:0] mac_w_im,
   input  logic signed [DW-1:0] mac_o1_re,
   input  logic signed [DW-1:0] mac_o1_im,
   input  logic signed [DW-1:0] mac_o2_re,
   input  logic signed [DW-1:0] mac_o2_im
);
   state_t                state_q, state_d;
   logic        [6:0]     cnt_q, cnt_d;
   logic signed [DW-1:0]  mem_re_q [N];
   logic signed [DW-1:0]  mem_im_q [N];
   logic signed [DW-1:0]  mem_re_d [N];
   logic signed [DW-1:0]  mem_im_d [N];

   logic        [2:0]     stage;
   logic        [4:0]     bfly, span_m, idx_a, idx_b;
   logic        [3:0]     tw_k;
   logic signed [TW-1:0]  rom_re, rom_im;
   logic                  in_compute;

   // cnt doubles as {stage, butterfly} during COMPUTE (0..79)
   always_comb begin
      stage  = cnt_q[6:4];
      bfly   = {1'b0, cnt_q[3:0]};
      span_m = (5'd1 << stage) - 5'd1;
      idx_a  = ((bfly & ~span_m) << 1) | (bfly & span_m);
      idx_b  = idx_a | (span_m + 5'd1);
      tw_k   = 4'((bfly & span_m) << (3'd4 - stage));
   end

   fft32_twiddle_rom u_rom (
      .k    (tw_k),
      .w_re (rom_re),
      .w_im (rom_im)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mem_re_d = mem_re_q;
      mem_im_d = mem_im_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               mem_re_d[bitrev5(cnt_q[4:0])] = in_re;
               mem_im_d[bitrev5(cnt_q[4:0])] = in_im;
               if (cnt_q == 7'd31) begin
                  state_d = COMPUTE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         COMPUTE: begin
            mem_re_d[idx_a] = mac_o1_re;
            mem_im_d[idx_a] = mac_o1_im;
            mem_re_d[idx_b] = mac_o2_re;
            mem_im_d[idx_b] = mac_o2_im;
            if (cnt_q == 7'd79) begin
               state_d = UNLOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         UNLOAD: begin
            if (out_ready) begin
               if (cnt_q == 7'd31) begin
                  state_d = LOAD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         default: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         for (int i = 0; i < N; i++) begin
            mem_re_q[i] <= '0;
            mem_im_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mem_re_q <= mem_re_d;
         mem_im_q <= mem_im_d;
      end
   end

   assign in_compute = (state_q == COMPUTE);
   assign in_ready   = (state_q == LOAD);
   assign out_valid  = (state_q == UNLOAD);
   assign busy       = in_compute || out_valid;
   assign frame_done = out_valid && out_ready && (cnt_q == 7'd31);
   assign out_re     = out_valid ? mem_re_q[cnt_q[4:0]] : '0;
   assign out_im     = out_valid ? mem_im_q[cnt_q[4:0]] : '0;

   assign mac_a_re = in_compute ? mem_re_q[idx_a] : '0;
   assign mac_a_im = in_compute ? mem_im_q[idx_a] : '0;
   assign mac_b_re = in_compute ? mem_re_q[idx_b] : '0;
   assign mac_b_im = in_compute ? mem_im_q[idx_b] : '0;
   assign mac_w_re = in_compute ? rom_re : '0;
   assign mac_w_im = in_compute ? rom_im : '0;
endmodule

// File: tb/tb_fft32_bfly_sequencer.sv
// Scoreboard bench for fft32_bfly_sequencer with a behavioural rounding/saturating butterfly MAC.
module tb_fft32_bfly_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic               in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy, frame_done;
   logic signed [12:0] in_re = '0, in_im = '0, out_re, out_im;
   logic signed [12:0] mac_a_re, mac_a_im, mac_b_re, mac_b_im;
   logic signed [7:0]  mac_w_re, mac_w_im;
   logic signed [12:0] mac_o1_re, mac_o1_im, mac_o2_re, mac_o2_im;
   int                 prod_re, prod_im;

   fft32_bfly_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .busy(busy), .frame_done(frame_done),
      .mac_a_re(mac_a_re), .mac_a_im(mac_a_im), .mac_b_re(mac_b_re), .mac_b_im(mac_b_im),
      .mac_w_re(mac_w_re), .mac_w_im(mac_w_im),
      .mac_o1_re(mac_o1_re), .mac_o1_im(mac_o1_im), .mac_o2_re(mac_o2_re), .mac_o2_im(mac_o2_im)
   );

   function automatic logic signed [12:0] sat13(input int v);
      if (v > 4095) return 13'sd4095;
      if (v < -4096) return 13'h1000;
      return 13'(v);
   endfunction

   function automatic int rnd6(input int p);
      return (p + 32) >>> 6;
   endfunction

   assign prod_re   = rnd6(int'(mac_b_re) * int'(mac_w_re) - int'(mac_b_im) * int'(mac_w_im));
   assign prod_im   = rnd6(int'(mac_b_re) * int'(mac_w_im) + int'(mac_b_im) * int'(mac_w_re));
   assign mac_o1_re = sat13(int'(mac_a_re) + prod_re);
   assign mac_o1_im = sat13(int'(mac_a_im) + prod_im);
   assign mac_o2_re = sat13(int'(mac_a_re) - prod_re);
   assign mac_o2_im = sat13(int'(mac_a_im) - prod_im);

   typedef struct {
      int re;
      int im;
      int tol;
      bit chk;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0, n_err = 0;
   int   hs_cnt = 0, fd_cnt = 0, out_idx = 0;
   bit   check_ready_next = 1'b0;
   int   xre[32], xim[32];
   int   er[32], ei[32];
   int   etol;
   bit   echk[32];
   int   wre[16] = '{64, 63, 59, 53, 45, 36, 24, 12, 0, -12, -24, -36, -45, -53, -59, -63};
   int   wim[16] = '{0, -12, -24, -36, -45, -53, -59, -63, -64, -63, -59, -53, -45, -36, -24, -12};

   task automatic chk(input string name, input int act, input int expv, input int tol);
      n_vec++;
      if (act > expv + tol || act < expv - tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, expv, tol);
      end
   endtask

   // Monitor: pops one expected entry per output handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (check_ready_next) begin
            chk("in_ready_after_done", int'(in_ready), 1, 0);
            check_ready_next = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got X%0d=%0d,%0d, expected no output", out_idx, out_re, out_im);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.chk) begin
                  chk($sformatf("X%0d_re", out_idx), int'(out_re), mon_e.re, mon_e.tol);
                  chk($sformatf("X%0d_im", out_idx), int'(out_im), mon_e.im, mon_e.tol);
               end
            end
            chk($sformatf("frame_done_at_%0d", out_idx), int'(frame_done), (out_idx == 31) ? 1 : 0, 0);
            if (frame_done) fd_cnt++;
            if (out_idx == 31) begin
               out_idx = 0;
               check_ready_next = 1'b1;
            end else begin
               out_idx++;
            end
            hs_cnt++;
         end else if (frame_done) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_frame_done: got 1, expected 0");
         end
      end
   end

   task automatic push_exp();
      for (int k = 0; k < 32; k++) begin
         exp_t e;
         e.re  = er[k];
         e.im  = ei[k];
         e.tol = etol;
         e.chk = echk[k];
         exp_q.push_back(e);
      end
   endtask

   task automatic clear_vectors();
      for (int n = 0; n < 32; n++) begin
         xre[n] = 0; xim[n] = 0; er[n] = 0; ei[n] = 0; echk[n] = 1'b1;
      end
      etol = 0;
   endtask

   task automatic send_frame();
      int w;
      for (int n = 0; n < 32; n++) begin
         in_valid = 1'b1;
         in_re    = 13'(xre[n]);
         in_im    = 13'(xim[n]);
         w = 0;
         @(negedge clk);
         while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready) chk($sformatf("in_ready_timeout_%0d", n), 0, 1, 0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic measure_compute();
      int c;
      c = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) break;
         if (busy) c++;
      end
      chk("compute_cycles", c, 80, 0);
   endtask

   task automatic wait_done(input int start_fd);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (fd_cnt > start_fd) break;
      end
      chk("frame_complete", fd_cnt, start_fd + 1, 0);
   endtask

   task automatic run_frame();
      int f0;
      f0 = fd_cnt;
      push_exp();
      send_frame();
      measure_compute();
      wait_done(f0);
   endtask

   initial begin
      int f0, h0;
      #12;
      chk("rst_in_ready", int'(in_ready), 1, 0);
      chk("rst_busy", int'(busy), 0, 0);
      chk("rst_out_valid", int'(out_valid), 0, 0);
      chk("rst_frame_done", int'(frame_done), 0, 0);
      chk("rst_out_re", int'(out_re), 0, 0);
      chk("rst_mac_a_re", int'(mac_a_re), 0, 0);
      chk("rst_mac_w_re", int'(mac_w_re), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Impulse with backpressure at X[7]
      clear_vectors();
      xre[0] = 100;
      for (int k = 0; k < 32; k++) er[k] = 100;
      f0 = fd_cnt;
      h0 = hs_cnt;
      push_exp();
      send_frame();
      measure_compute();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (out_idx == 7) break;
      end
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", int'(out_valid), 1, 0);
         chk("stall_re", int'(out_re), er[7], 0);
         chk("stall_im", int'(out_im), ei[7], 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_done(f0);
      chk("impulse_handshakes", hs_cnt - h0, 32, 0);

      // x[1]=64: X[k] = W^k exactly
      clear_vectors();
      xre[1] = 64;
      for (int k = 0; k < 16; k++) begin
         er[k] = wre[k];       ei[k] = wim[k];
         er[k + 16] = -wre[k]; ei[k + 16] = -wim[k];
      end
      run_frame();

      // x[2]=64: X[k] = W^(2k)
      clear_vectors();
      xre[2] = 64;
      for (int k = 0; k < 32; k++) begin
         er[k] = (((k % 16) < 8) ? 1 : -1) * wre[2 * (k % 8)];
         ei[k] = (((k % 16) < 8) ? 1 : -1) * wim[2 * (k % 8)];
      end
      run_frame();

      // DC
      clear_vectors();
      for (int n = 0; n < 32; n++) xre[n] = 10;
      er[0] = 320;
      etol = 1;
      run_frame();

      // Alternating sign
      clear_vectors();
      for (int n = 0; n < 32; n++) xre[n] = (n % 2 == 0) ? 50 : -50;
      er[16] = 1600;
      etol = 1;
      run_frame();

      // Saturation: only the DC bin is well defined
      clear_vectors();
      for (int n = 0; n < 32; n++) begin
         xre[n] = 4000;
         echk[n] = 1'b0;
      end
      er[0] = 4095;
      echk[0] = 1'b1;
      run_frame();

      // Reset in the middle of COMPUTE
      clear_vectors();
      for (int n = 0; n < 32; n++) xre[n] = 10;
      send_frame();
      for (int i = 0; i < 39; i++) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", int'(in_ready), 1, 0);
      chk("midrst_busy", int'(busy), 0, 0);
      chk("midrst_out_valid", int'(out_valid), 0, 0);
      chk("midrst_mac_b_re", int'(mac_b_re), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("postrst_in_ready", int'(in_ready), 1, 0);

      clear_vectors();
      xre[0] = -37;
      xim[0] = 25;
      for (int k = 0; k < 32; k++) begin
         er[k] = -37;
         ei[k] = 25;
      end
      run_frame();

      chk("scoreboard_empty", exp_q.size(), 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
